cpu_run_sequencer: RTL and testbench

CPU_RUN_SEQUENCER -- requirements
Module: cpu_run_sequencer

---
 rtl/cpu_run_sequencer.sv | 107 ++++++++++
 tb/tb_cpu_run_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cpu_run_sequencer.sv
// Launches one CPU program run per host request. The CPU is reset and then started,
// its run length is measured in cycles, and the result is held until the host takes it.
//
// state | meaning
// IDLE  | waiting for run_req
// CLR   | one cycle: acknowledge the request and hold the CPU in reset
// START | one cycle: pulse cpu_start and clear the cycle counter
// RUN   | count cycles until cpu_done or TIMEOUT
// RESP  | present res_cycles/res_timeout until res_ready
module cpu_run_sequencer #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_req,
   output logic             run_ack,
   output logic             busy,
   output logic             cpu_rst,
   output logic             cpu_start,
   input  logic             cpu_done,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_cycles,
   output logic             res_timeout
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_START = 3'd2,
      ST_RUN   = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] res_cycles_q, res_cycles_d;
   logic             res_timeout_q, res_timeout_d;
   logic [CNT_W-1:0] cnt_inc;

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         res_cycles_q  <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         res_cycles_q  <= res_cycles_d;
         res_timeout_q <= res_timeout_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      res_cycles_d  = res_cycles_q;
      res_timeout_d = res_timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (run_req) state_d = ST_CLR;
         end
         ST_CLR: begin
            state_d = ST_START;
         end
         ST_START: begin
            cnt_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            // cpu_done takes priority over the timeout on the final cycle
            if (cpu_done) begin
               res_cycles_d  = cnt_inc;
               res_timeout_d = 1'b0;
               state_d       = ST_RESP;
            end else if (cnt_inc == TIMEOUT_C) begin
               res_cycles_d  = TIMEOUT_C;
               res_timeout_d = 1'b1;
               state_d       = ST_RESP;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_RESP: begin
            if (res_ready) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign run_ack     = (state_q == ST_CLR);
   assign cpu_start   = (state_q == ST_START);
   assign busy        = (state_q != ST_IDLE);
   assign res_valid   = (state_q == ST_RESP);
   assign cpu_rst     = rst | (state_q == ST_CLR);
   assign res_cycles  = res_cycles_q;
   assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Bench for cpu_run_sequencer with TIMEOUT=8: directed corner runs followed by
// randomized runs, each checked against a cycle-count model of the run outcome.
module tb_cpu_run_sequencer;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             run_req;
   logic             run_ack;
   logic             busy;
   logic             cpu_rst;
   logic             cpu_start;
   logic             cpu_done;
   logic             res_valid;
   logic             res_ready;
   logic [CNT_W-1:0] res_cycles;
   logic             res_timeout;

   int n_checks = 0;
   int n_errs   = 0;

   cpu_run_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .run_req    (run_req),
      .run_ack    (run_ack),
      .busy       (busy),
      .cpu_rst    (cpu_rst),
      .cpu_start  (cpu_start),
      .cpu_done   (cpu_done),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_cycles (res_cycles),
      .res_timeout(res_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   // advance one clock; sample/drive 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full run starting from IDLE. done_at = RUN cycle (1-based) in which cpu_done
   // is raised; any value outside 1..TIMEOUT means the CPU never finishes.
   task automatic do_run(input int done_at, input bit early_done, input int ready_delay,
                         input bit hold_req);
      int exp_cycles;
      bit exp_to;
      int n;
      exp_to     = !(done_at >= 1 && done_at <= TIMEOUT);
      exp_cycles = exp_to ? TIMEOUT : done_at;

      run_req = 1'b1;
      step();
      check("clr_ack", run_ack, 1);
      check("clr_cpu_rst", cpu_rst, 1);
      check("clr_start", cpu_start, 0);
      check("clr_busy", busy, 1);
      run_req  = 1'($urandom);
      cpu_done = early_done;
      step();
      check("start_pulse", cpu_start, 1);
      check("start_ack", run_ack, 0);
      check("start_cpu_rst", cpu_rst, 0);
      run_req  = 1'($urandom);
      cpu_done = early_done;
      step();

      n = 0;
      while (!res_valid && n < TIMEOUT + 4) begin
         check("run_valid", res_valid, 0);
         check("run_ack_low", run_ack, 0);
         check("run_start_low", cpu_start, 0);
         n++;
         cpu_done = (n == done_at);
         run_req  = 1'($urandom);
         step();
      end
      cpu_done = 1'b0;
      check("run_len", n, exp_cycles);
      check("resp_valid", res_valid, 1);
      check("resp_cycles", res_cycles, exp_cycles);
      check("resp_timeout", res_timeout, exp_to);

      for (int i = 0; i < ready_delay; i++) begin
         res_ready = 1'b0;
         run_req   = 1'($urandom);
         cpu_done  = 1'($urandom);
         step();
         check("bp_valid", res_valid, 1);
         check("bp_cycles", res_cycles, exp_cycles);
         check("bp_timeout", res_timeout, exp_to);
         check("bp_ack", run_ack, 0);
         check("bp_start", cpu_start, 0);
      end
      cpu_done  = 1'b0;
      res_ready = 1'b1;
      run_req   = hold_req;
      step();
      res_ready = 1'b0;
      check("idle_busy", busy, 0);
      check("idle_valid", res_valid, 0);
      check("idle_ack", run_ack, 0);
      check("idle_cycles_hold", res_cycles, exp_cycles);
      check("idle_timeout_hold", res_timeout, exp_to);
   endtask

   initial begin
      rst       = 1'b1;
      run_req   = 1'b0;
      cpu_done  = 1'b0;
      res_ready = 1'b0;
      step();
      step();
      check("rst_busy", busy, 0);
      check("rst_valid", res_valid, 0);
      check("rst_ack", run_ack, 0);
      check("rst_start", cpu_start, 0);
      check("rst_cpu_rst", cpu_rst, 1);
      check("rst_cycles", res_cycles, 0);
      check("rst_timeout", res_timeout, 0);
      rst = 1'b0;
      #1;
      check("cpu_rst_release", cpu_rst, 0);
      step();
      check("idle_no_req", busy, 0);

      do_run(3, 1'b0, 0, 1'b0);   // nominal
      do_run(0, 1'b0, 0, 1'b0);   // timeout
      do_run(8, 1'b0, 0, 1'b0);   // done on timeout cycle
      do_run(4, 1'b0, 5, 1'b1);   // backpressure, held request restarts
      do_run(2, 1'b1, 1, 1'b0);   // early done ignored
      do_run(1, 1'b0, 0, 1'b0);   // minimum latency

      // reset in the 2nd RUN cycle aborts without a result
      run_req = 1'b1;
      step();
      run_req = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      #1;
      check("abort_cpu_rst", cpu_rst, 1);
      step();
      check("abort_busy", busy, 0);
      check("abort_valid", res_valid, 0);
      check("abort_cpu_rst_hold", cpu_rst, 1);
      check("abort_cycles", res_cycles, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("abort_no_result", res_valid, 0);
      end

      for (int r = 0; r < 40; r++) begin
         do_run(int'($urandom_range(0, 10)), 1'($urandom), int'($urandom_range(0, 3)),
                1'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
